// File: rtl/creat_b.sv
// HDB3 encoder stage 2: replaces the first zero of a 000V group with B when the marks since the last V are even.
// Optional sticky code-error checker enabled by defining CREAT_B_CHK_EN (adds port code_err).
module creat_b #(
  parameter logic INIT_PAR = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] data_in_v,
  output logic [1:0] data_out_b
`ifdef CREAT_B_CHK_EN
  ,
  output logic       code_err
`endif
);

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_MARK = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  logic [1:0] sr0, sr1, sr2, sr3;
  logic       par;
  logic       par_nxt;
  logic       ins_b;

  // A V with even parity turns the oldest queued zero (about to reach sr3) into B
  always_comb begin
    ins_b   = (data_in_v == SYM_V) && !par;
    par_nxt = par;
    case (data_in_v)
      SYM_MARK: par_nxt = ~par;
      SYM_V:    par_nxt = 1'b0;
      default:  par_nxt = par;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr0 <= SYM_ZERO;
      sr1 <= SYM_ZERO;
      sr2 <= SYM_ZERO;
      sr3 <= SYM_ZERO;
      par <= INIT_PAR;
    end else begin
      sr0 <= data_in_v;
      sr1 <= sr0;
      sr2 <= sr1;
      sr3 <= ins_b ? SYM_B : sr2;
      par <= par_nxt;
    end
  end

  assign data_out_b = sr3;

`ifdef CREAT_B_CHK_EN
  logic bad_sym;

  // Illegal B from upstream, or a V not preceded by three zeros
  always_comb begin
    bad_sym = (data_in_v == SYM_B) ||
              ((data_in_v == SYM_V) &&
               ((sr0 != SYM_ZERO) || (sr1 != SYM_ZERO) || (sr2 != SYM_ZERO)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_err <= 1'b0;
    end else if (bad_sym) begin
      code_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_creat_b.sv
// Directed bench for creat_b: a symbol-history model checked every cycle plus literal expected vectors.
// Builds with or without CREAT_B_CHK_EN.
module tb_creat_b;

  localparam logic INIT_PAR = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] data_in_v = 2'b00;
  logic [1:0] data_out_b;
`ifdef CREAT_B_CHK_EN
  logic       code_err;
`endif

  always #5 clk = ~clk;

  creat_b #(.INIT_PAR(INIT_PAR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in_v  (data_in_v),
    .data_out_b (data_out_b)
`ifdef CREAT_B_CHK_EN
    ,
    .code_err   (code_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Model: history of symbols in sampling order, preceded by the four reset-fill zeros.
  // The symbol pushed on edge k is emitted after edge k+3.
  logic [1:0] hist[$];
  int         k;
  int         marks;
  logic [1:0] exp_out = 2'b00;
  logic       exp_err = 1'b0;
  bit         model_on = 1'b0;

  function automatic void model_reset();
    hist    = {2'b00, 2'b00, 2'b00, 2'b00};
    k       = 0;
    marks   = int'(INIT_PAR);
    exp_out = 2'b00;
    exp_err = 1'b0;
  endfunction

  function automatic void model_push(input logic [1:0] sym);
    int j;
    j = hist.size();
    if (sym == 2'b10) exp_err = 1'b1;
    if (sym == 2'b11 && (hist[j-1] != 2'b00 || hist[j-2] != 2'b00 || hist[j-3] != 2'b00))
      exp_err = 1'b1;
    if (sym == 2'b11 && (marks % 2) == 0) hist[j-3] = 2'b10;
    hist.push_back(sym);
    if (sym == 2'b01) marks++;
    if (sym == 2'b11) marks = 0;
    k++;
    exp_out = hist[k];
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      check("stream", data_out_b, exp_out);
`ifdef CREAT_B_CHK_EN
      check("code_err_stream", {1'b0, code_err}, {1'b0, exp_err});
`endif
    end
  end

  logic [1:0] got[$];
  logic [1:0] vin[$];
  logic [1:0] vexp[$];

  // Called at negedge+2; returns at the following negedge+2
  task automatic step(input logic [1:0] sym);
    data_in_v = sym;
    @(posedge clk);
    if (rst_n) model_push(sym);
    #1 got.push_back(data_out_b);
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [1:0] hold_sym);
    rst_n = 1'b0;
    model_reset();
    #1 check("rst_flush", data_out_b, 2'b00);
`ifdef CREAT_B_CHK_EN
    check("rst_code_err", {1'b0, code_err}, 2'b00);
`endif
    data_in_v = hold_sym;
    repeat (2) begin
      @(posedge clk);
      #1 check("rst_hold", data_out_b, 2'b00);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    got.delete();
  endtask

  task automatic run_vec(input string name);
    got.delete();
    foreach (vin[i]) step(vin[i]);
    repeat (3) step(2'b00);
    foreach (vexp[i]) check(name, got[i+3], vexp[i]);
  endtask

  initial begin
    #2;
    model_on = 1'b1;

    // Reset holds output at zero while 01 is driven; first 01 emerges after edge 4
    do_reset(2'b01);
    step(2'b01);
    step(2'b00);
    step(2'b00);
    step(2'b00);
    check("rst_lat_e1", got[0], 2'b00);
    check("rst_lat_e3", got[2], 2'b00);
    check("rst_lat_e4", got[3], 2'b01);

    // Even marks before V: B inserted
    do_reset(2'b00);
    vin  = {2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    vexp = {2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    run_vec("even_marks");

    // Odd marks: no B
    do_reset(2'b00);
    vin  = {2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    vexp = {2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    run_vec("odd_marks");

    // Back-to-back groups straight from reset
    do_reset(2'b00);
    vin  = {2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    vexp = {2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11};
    run_vec("back_to_back");

    // V right after reset replaces a reset-fill zero
    do_reset(2'b00);
    vin  = {2'b11, 2'b00};
    vexp = {2'b11, 2'b00};
    run_vec("early_v");

    // Longer legal stream: odd then zero marks between V's
    do_reset(2'b00);
    vin  = {2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11,
            2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    vexp = {2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11,
            2'b10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    run_vec("long_stream");

    // Reset mid-group flushes the line and restores even parity
    do_reset(2'b00);
    step(2'b01);
    step(2'b00);
    step(2'b00);
    do_reset(2'b00);
    vin  = {2'b00, 2'b00, 2'b00, 2'b11};
    vexp = {2'b10, 2'b00, 2'b00, 2'b11};
    run_vec("mid_reset");

    // Illegal 10 is forwarded and does not count as a mark
    do_reset(2'b00);
    step(2'b10);
`ifdef CREAT_B_CHK_EN
    check("err_on_b", {1'b0, code_err}, 2'b01);
`endif
    vin  = {2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    vexp = {2'b01, 2'b00, 2'b00, 2'b00, 2'b11};
    run_vec("illegal_b");
    check("illegal_b_fwd", got[0], 2'b00);
`ifdef CREAT_B_CHK_EN
    check("err_sticky", {1'b0, code_err}, 2'b01);
`endif

    // V without three preceding zeros
    do_reset(2'b00);
    step(2'b01);
    step(2'b11);
`ifdef CREAT_B_CHK_EN
    check("err_v_no_zeros", {1'b0, code_err}, 2'b01);
`endif
    repeat (3) step(2'b00);
    check("v_no_zeros_mark", got[3], 2'b01);
    check("v_no_zeros_v", got[4], 2'b11);

    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
